output_serializer: RTL and testbench

Parametrised result serializer that sits between the calculation datapath and the narrow chip output pins. It captures an ANS_W-bit result on a valid/ready handshake and streams it out as CHUNK_W-bit chunks. Each chunk carries valid and last flags. The downstream side can stall the stream, and a new result can follow the previous one with no idle cycles.

---
 rtl/output_pkg.sv | 13 +
 rtl/output_serializer.sv | 69 ++++++
 tb/tb_output_serializer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/output_pkg.sv
// Shared types and constants for the result serializer.
package output_pkg;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam int VALID_BIT = 1;
  localparam int LAST_BIT  = 0;

  function automatic int num_chunks(input int ans_w, input int chunk_w);
    return (ans_w + chunk_w - 1) / chunk_w;
  endfunction

endpackage

// File: rtl/output_serializer.sv
// Captures an ANS_W-bit result on valid/ready and streams it as CHUNK_W-bit beats
// with valid/last flags; out_stall holds the current beat, back-to-back results need no gap.
module output_serializer
  import output_pkg::*;
#(
  parameter int ANS_W     = 16,
  parameter int CHUNK_W   = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [ANS_W-1:0]   ans,
  input  logic               ans_valid,
  output logic               ans_ready,
  input  logic               out_stall,
  output logic [CHUNK_W+1:0] out,
  output logic               busy
);

  localparam int NUM_CHUNKS = num_chunks(ANS_W, CHUNK_W);
  localparam int PAD_W      = NUM_CHUNKS * CHUNK_W;
  localparam int CNT_W      = $clog2(NUM_CHUNKS + 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [PAD_W-1:0]   cap;
  logic [PAD_W-1:0]   ans_pad;
  logic               capture;

  // j is the position in send order; map it to the chunk index in the padded word.
  function automatic logic [CHUNK_W-1:0] pick(input logic [PAD_W-1:0] w, input int j);
    int i;
    i = MSB_FIRST ? (NUM_CHUNKS - 1 - j) : j;
    return w[i*CHUNK_W +: CHUNK_W];
  endfunction

  assign ans_pad   = PAD_W'(ans);
  assign ans_ready = (state == IDLE) ||
                     ((state == SEND) && out[LAST_BIT] && !out_stall);
  assign capture   = ans_valid && ans_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      cap   <= '0;
      out   <= '0;
      busy  <= 1'b0;
    end else if (capture) begin
      cap   <= ans_pad;
      out   <= {pick(ans_pad, 0), 1'b1, (NUM_CHUNKS == 1)};
      cnt   <= CNT_W'(1);
      state <= SEND;
      busy  <= 1'b1;
    end else if (state == SEND && !out_stall) begin
      if (out[LAST_BIT]) begin
        out   <= '0;
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        out <= {pick(cap, int'(cnt)), 1'b1, (int'(cnt) == NUM_CHUNKS - 1)};
        cnt <= cnt + CNT_W'(1);
      end
    end else if (state == IDLE) begin
      out <= '0;
    end
  end

endmodule

// File: tb/tb_output_serializer.sv
// Directed bench for output_serializer across four parameter sets, checked each
// cycle against a beat-queue model plus hand-computed literal beats.
module tb_output_serializer;

  localparam int NI = 4;
  // Instance parameter sets: {ANS_W, MSB_FIRST}; CHUNK_W is 8 everywhere.
  localparam int AW [NI] = '{16, 12, 24, 8};
  localparam bit MF [NI] = '{1'b1, 1'b1, 1'b0, 1'b1};

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ans_a   [NI];
  logic        valid_a [NI];
  logic        stall_a [NI];
  logic        ready_a [NI];
  logic        busy_a  [NI];
  logic [9:0]  dout    [NI];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  output_serializer #(.ANS_W(16), .CHUNK_W(8), .MSB_FIRST(1'b1)) u0 (
    .clock(clock), .reset(reset), .ans(ans_a[0][15:0]), .ans_valid(valid_a[0]),
    .ans_ready(ready_a[0]), .out_stall(stall_a[0]), .out(dout[0]), .busy(busy_a[0]));
  output_serializer #(.ANS_W(12), .CHUNK_W(8), .MSB_FIRST(1'b1)) u1 (
    .clock(clock), .reset(reset), .ans(ans_a[1][11:0]), .ans_valid(valid_a[1]),
    .ans_ready(ready_a[1]), .out_stall(stall_a[1]), .out(dout[1]), .busy(busy_a[1]));
  output_serializer #(.ANS_W(24), .CHUNK_W(8), .MSB_FIRST(1'b0)) u2 (
    .clock(clock), .reset(reset), .ans(ans_a[2][23:0]), .ans_valid(valid_a[2]),
    .ans_ready(ready_a[2]), .out_stall(stall_a[2]), .out(dout[2]), .busy(busy_a[2]));
  output_serializer #(.ANS_W(8), .CHUNK_W(8), .MSB_FIRST(1'b1)) u3 (
    .clock(clock), .reset(reset), .ans(ans_a[3][7:0]), .ans_valid(valid_a[3]),
    .ans_ready(ready_a[3]), .out_stall(stall_a[3]), .out(dout[3]), .busy(busy_a[3]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the remaining beats of the result in flight, in send order.
  logic [9:0] mb   [NI][8];
  int         mrem [NI];
  int         mpos [NI];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NI; k++) begin
        mrem[k] <= 0;
        mpos[k] <= 0;
      end
    end else begin
      for (int k = 0; k < NI; k++) begin
        int  nc;
        bit  rdy;
        nc  = (AW[k] + 7) / 8;
        rdy = (mrem[k] == 0) || (mrem[k] == 1 && !stall_a[k]);
        if (valid_a[k] && rdy) begin
          for (int j = 0; j < nc; j++) begin
            int       ci;
            logic [7:0] c;
            ci = MF[k] ? (nc - 1 - j) : j;
            c  = 8'((ans_a[k] & ((32'h1 << AW[k]) - 1)) >> (8 * ci));
            mb[k][j] <= {c, 1'b1, (j == nc - 1)};
          end
          mpos[k] <= 0;
          mrem[k] <= nc;
        end else if (mrem[k] > 0 && !stall_a[k]) begin
          mpos[k] <= mpos[k] + 1;
          mrem[k] <= mrem[k] - 1;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      for (int k = 0; k < NI; k++) begin
        logic [9:0] e;
        e = (mrem[k] > 0) ? mb[k][mpos[k]] : 10'h0;
        chk($sformatf("model_out[%0d]", k), 32'(dout[k]), 32'(e));
        chk($sformatf("model_busy[%0d]", k), 32'(busy_a[k]), 32'(mrem[k] > 0));
        chk($sformatf("model_ready[%0d]", k), 32'(ready_a[k]),
            32'((mrem[k] == 0) || (mrem[k] == 1 && !stall_a[k])));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      ans_a[k] = '0; valid_a[k] = 1'b0; stall_a[k] = 1'b0;
    end
    #1;
    chk("reset_out", 32'(dout[0]), 32'h0);
    chk("reset_busy", 32'(busy_a[0]), 32'h0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Basic two-beat result
    ans_a[0] = 32'hA55A; valid_a[0] = 1'b1;
    tick(); valid_a[0] = 1'b0;
    chk("t1_beat0", 32'(dout[0]), 32'h296);
    chk("t1_busy0", 32'(busy_a[0]), 32'h1);
    tick(); chk("t1_beat1", 32'(dout[0]), 32'h16B);
    chk("t1_busy1", 32'(busy_a[0]), 32'h1);
    tick(); chk("t1_idle", 32'(dout[0]), 32'h0);
    chk("t1_busy2", 32'(busy_a[0]), 32'h0);

    // Stall holds the first beat
    ans_a[0] = 32'hA55A; valid_a[0] = 1'b1;
    tick(); valid_a[0] = 1'b0; stall_a[0] = 1'b1; #1;
    chk("t2_hold0", 32'(dout[0]), 32'h296);
    chk("t2_ready0", 32'(ready_a[0]), 32'h0);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk($sformatf("t2_hold%0d", i), 32'(dout[0]), 32'h296);
      chk($sformatf("t2_ready%0d", i), 32'(ready_a[0]), 32'h0);
    end
    stall_a[0] = 1'b0;
    tick(); chk("t2_last", 32'(dout[0]), 32'h16B);
    tick(); chk("t2_idle", 32'(dout[0]), 32'h0);

    // Back-to-back results with ans_valid held
    ans_a[0] = 32'h1234; valid_a[0] = 1'b1;
    tick(); chk("t3_12", 32'(dout[0]), 32'h04A);
    ans_a[0] = 32'hBEEF;
    tick(); chk("t3_34", 32'(dout[0]), 32'h0D3);
    tick(); valid_a[0] = 1'b0;
    chk("t3_BE", 32'(dout[0]), 32'h2FA);
    tick(); chk("t3_EF", 32'(dout[0]), 32'h3BF);
    tick(); chk("t3_idle", 32'(dout[0]), 32'h0);

    // Zero padding at the MSB end
    ans_a[1] = 32'hABC; valid_a[1] = 1'b1;
    tick(); valid_a[1] = 1'b0;
    chk("t4_0A", 32'(dout[1]), 32'h02A);
    tick(); chk("t4_BC", 32'(dout[1]), 32'h2F3);
    tick();

    // LSB-first order
    ans_a[2] = 32'h112233; valid_a[2] = 1'b1;
    tick(); valid_a[2] = 1'b0;
    chk("t5_33", 32'(dout[2]), 32'h0CE);
    tick(); chk("t5_22", 32'(dout[2]), 32'h08A);
    tick(); chk("t5_11", 32'(dout[2]), 32'h047);
    tick();

    // Single-chunk results stream every cycle, with one stall
    ans_a[3] = 32'h5A; valid_a[3] = 1'b1;
    tick(); chk("t7_5A", 32'(dout[3]), 32'h16B);
    ans_a[3] = 32'hC3;
    tick(); chk("t7_C3", 32'(dout[3]), 32'h30F);
    ans_a[3] = 32'h01; stall_a[3] = 1'b1;
    tick(); chk("t7_stall", 32'(dout[3]), 32'h30F);
    stall_a[3] = 1'b0;
    tick(); valid_a[3] = 1'b0;
    chk("t7_01", 32'(dout[3]), 32'h007);
    tick(); chk("t7_idle", 32'(dout[3]), 32'h0);

    // Async reset mid-stream, then a fresh result
    ans_a[0] = 32'hA55A; valid_a[0] = 1'b1;
    tick(); valid_a[0] = 1'b0;
    chk("t6_beat0", 32'(dout[0]), 32'h296);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_out", 32'(dout[0]), 32'h0);
    chk("t6_rst_busy", 32'(busy_a[0]), 32'h0);
    tick(); reset = 1'b0;
    tick();
    ans_a[0] = 32'h00FF; valid_a[0] = 1'b1;
    tick(); valid_a[0] = 1'b0;
    chk("t6_00", 32'(dout[0]), 32'h002);
    tick(); chk("t6_FF", 32'(dout[0]), 32'h3FF);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
